// File: rtl/axi_test_pkg.sv
// Shared definitions for the AXI4 self-test run-sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default counter widths, and a helper that
// classifies which states count as "run in progress".
package axi_test_pkg;

   // Default widths: iteration/statistics counters, inter-iteration gap,
   // per-iteration watchdog limit.
   localparam int ITER_W_DEF = 16;
   localparam int GAP_W_DEF  = 8;
   localparam int TMO_W_DEF  = 20;

   // State encoding is exported on the probe port, so the values are fixed.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } sched_state_t;

   // A run is in progress while launching, waiting on the engine, or idling
   // between iterations. S_DONE is deliberately excluded.
   function automatic logic is_run_state(input sched_state_t s);
      return (s == S_REQ) || (s == S_WAIT) || (s == S_GAP);
   endfunction

endpackage

// File: rtl/axi_test_sched_dncnt.sv
// Loadable down-counter with a zero flag, used for the inter-iteration gap
// and for the per-iteration watchdog.
// Latency: load/decrement visible the cycle after; zero is a decode of the count.
// Backpressure: none; dec at zero holds the count at zero.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset (count -> 0)
//   load       load load_val (takes priority over dec)
//   load_val   value to load
//   dec        decrement by one when the count is nonzero
//   cnt        current count
//   zero       high while cnt == 0
module sched_dncnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/axi_test_sched.sv
// Run-sequencer for the AXI4 master self-test engine: launches iter_num
// iterations via one-cycle req pulses, waits for ack, samples err, and keeps
// pass/fail statistics with an optional idle gap between iterations.
// Latency: outputs are registered and follow the FSM state by one cycle
//   (req appears the cycle after S_REQ, done the cycle after S_DONE).
// Backpressure: the engine paces the run through ack; start is ignored while a
//   run is in progress; abort wins over everything and drops back to idle.
//
// Optional feature: define AXI_SCHED_TMO_EN to build the per-iteration
// watchdog (tmo_cycles, tmo_cnt). Without it S_WAIT only exits on ack or abort.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        launch a run (accepted in S_IDLE only)
//   abort        cancel the run, counters hold, no done pulse
//   iter_num     iterations per run, latched on start
//   gap_cycles   idle cycles between iterations, latched on start
//   tmo_cycles   watchdog limit per iteration (0 = off), latched on start
//   req          one-cycle launch pulse to the engine
//   ack, err     engine completion level and sticky error
//   busy         run in progress (lags state by one cycle like all outputs)
//   done         one-cycle pulse on run completion
//   pass_cnt, fail_cnt, tmo_cnt   per-run statistics
//   last_err     error result of the most recent finished iteration
//   state        FSM state for probing
module axi_test_sched
   import axi_test_pkg::*;
#(
   parameter int ITER_W = ITER_W_DEF,
   parameter int GAP_W  = GAP_W_DEF,
   parameter int TMO_W  = TMO_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ITER_W-1:0] iter_num,
   input  logic [GAP_W-1:0]  gap_cycles,
   input  logic [TMO_W-1:0]  tmo_cycles,
   output logic              req,
   input  logic              ack,
   input  logic              err,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] pass_cnt,
   output logic [ITER_W-1:0] fail_cnt,
   output logic [ITER_W-1:0] tmo_cnt,
   output logic              last_err,
   output logic [2:0]        state
);

   sched_state_t      state_q;
   logic [ITER_W-1:0] iter_lat;
   logic [ITER_W-1:0] iter_idx;
   logic [ITER_W-1:0] iter_nxt;
   logic [GAP_W-1:0]  gap_lat;
   logic [GAP_W-1:0]  unused_gap_cnt;

   logic ack_ok;     // ack is meaningful: in S_WAIT and the req cycle is over
   logic ack_take;   // ack actually counted (an abort discards it)
   logic tmo_hit;    // watchdog expired this cycle without an ack
   logic fin;        // current iteration finishes this cycle
   logic last_iter;  // the finishing iteration is the final one of the run
   logic gap_load;
   logic gap_zero;

   // During the cycle req is high the engine may still be showing the ack of
   // the previous iteration; it only clears ack after seeing req.
   assign ack_ok    = (state_q == S_WAIT) && !req && ack;
   assign ack_take  = ack_ok && !abort;
   assign fin       = ack_take || tmo_hit;
   assign iter_nxt  = iter_idx + ITER_W'(1);
   assign last_iter = (iter_nxt == iter_lat);
   assign gap_load  = fin && !last_iter && (gap_lat != '0);

   // Loaded with gap-1 on leaving S_WAIT so that S_GAP lasts exactly
   // gap_cycles cycles: the zero flag is seen in the last of them.
   sched_dncnt #(
      .W (GAP_W)
   ) u_gap (
      .clk      (clk),
      .rst      (rst),
      .load     (gap_load),
      .load_val (gap_lat - GAP_W'(1)),
      .dec      (state_q == S_GAP),
      .cnt      (unused_gap_cnt),
      .zero     (gap_zero)
   );

`ifdef AXI_SCHED_TMO_EN
   logic [TMO_W-1:0]  tmo_lat;
   logic [TMO_W-1:0]  unused_wd_cnt;
   logic              wd_zero;
   logic [ITER_W-1:0] tmo_q;

   // Loaded with limit-1 in S_REQ; every S_WAIT cycle (including the one with
   // req high) counts, so expiry lands on the tmo_cycles-th cycle in S_WAIT.
   sched_dncnt #(
      .W (TMO_W)
   ) u_wd (
      .clk      (clk),
      .rst      (rst),
      .load     (state_q == S_REQ),
      .load_val (tmo_lat - TMO_W'(1)),
      .dec      (state_q == S_WAIT),
      .cnt      (unused_wd_cnt),
      .zero     (wd_zero)
   );

   // An ack in the same cycle takes precedence over the timeout.
   assign tmo_hit = (state_q == S_WAIT) && (tmo_lat != '0) && wd_zero
                    && !ack_ok && !abort;
   assign tmo_cnt = tmo_q;
`else
   logic unused_tmo;
   assign unused_tmo = ^tmo_cycles;
   assign tmo_hit    = 1'b0;
   assign tmo_cnt    = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         req      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         last_err <= 1'b0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         iter_idx <= '0;
         iter_lat <= '0;
         gap_lat  <= '0;
`ifdef AXI_SCHED_TMO_EN
         tmo_lat  <= '0;
         tmo_q    <= '0;
`endif
      end else begin
         req  <= 1'b0;
         done <= 1'b0;
         busy <= !abort && is_run_state(state_q);

         if (abort) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     iter_lat <= iter_num;
                     gap_lat  <= gap_cycles;
                     iter_idx <= '0;
                     pass_cnt <= '0;
                     fail_cnt <= '0;
`ifdef AXI_SCHED_TMO_EN
                     tmo_lat  <= tmo_cycles;
                     tmo_q    <= '0;
`endif
                     state_q  <= (iter_num == '0) ? S_DONE : S_REQ;
                  end
               end

               S_REQ: begin
                  req     <= 1'b1;
                  state_q <= S_WAIT;
               end

               S_WAIT: begin
                  if (ack_take) begin
                     if (err) begin
                        fail_cnt <= fail_cnt + ITER_W'(1);
                        last_err <= 1'b1;
                     end else begin
                        pass_cnt <= pass_cnt + ITER_W'(1);
                        last_err <= 1'b0;
                     end
                  end
`ifdef AXI_SCHED_TMO_EN
                  else if (tmo_hit) begin
                     tmo_q    <= tmo_q + ITER_W'(1);
                     fail_cnt <= fail_cnt + ITER_W'(1);
                     last_err <= 1'b1;
                  end
`endif
                  if (fin) begin
                     iter_idx <= iter_nxt;
                     if (last_iter) begin
                        state_q <= S_DONE;
                     end else if (gap_lat == '0) begin
                        state_q <= S_REQ;
                     end else begin
                        state_q <= S_GAP;
                     end
                  end
               end

               S_GAP: begin
                  if (gap_zero) begin
                     state_q <= S_REQ;
                  end
               end

               S_DONE: begin
                  done    <= 1'b1;
                  state_q <= S_IDLE;
               end

               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_axi_test_sched.sv
// Directed bench for axi_test_sched with a behavioural engine that acks a
// fixed number of cycles after each req, with a per-ack error plan.
// Define AXI_SCHED_TMO_EN to include the watchdog scenario.
module tb_axi_test_sched;

   localparam int ITER_W = 16;
   localparam int GAP_W  = 8;
   localparam int TMO_W  = 20;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [ITER_W-1:0] iter_num;
   logic [GAP_W-1:0]  gap_cycles;
   logic [TMO_W-1:0]  tmo_cycles;
   logic              req;
   logic              ack;
   logic              err;
   logic              busy;
   logic              done;
   logic [ITER_W-1:0] pass_cnt;
   logic [ITER_W-1:0] fail_cnt;
   logic [ITER_W-1:0] tmo_cnt;
   logic              last_err;
   logic [2:0]        state;

   axi_test_sched #(
      .ITER_W (ITER_W),
      .GAP_W  (GAP_W),
      .TMO_W  (TMO_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .iter_num   (iter_num),
      .gap_cycles (gap_cycles),
      .tmo_cycles (tmo_cycles),
      .req        (req),
      .ack        (ack),
      .err        (err),
      .busy       (busy),
      .done       (done),
      .pass_cnt   (pass_cnt),
      .fail_cnt   (fail_cnt),
      .tmo_cnt    (tmo_cnt),
      .last_err   (last_err),
      .state      (state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int req_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int req_cyc[$];

   // Engine model controls.
   int       eng_dly = 5;
   bit       eng_never = 1'b0;
   bit [7:0] err_bits = '0;
   int       eng_idx = 0;
   int       eng_cnt = 0;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial forever begin
      @(negedge clk);
      if (req === 1'b1) begin
         req_cnt = req_cnt + 1;
         req_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   // Engine: on req, clear ack/err and start the delay; ack rises eng_dly
   // cycles after the req cycle and holds until the next req.
   initial begin
      ack = 1'b0;
      err = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            ack = 1'b0;
            err = 1'b0;
            eng_cnt = 0;
         end else if (req) begin
            ack = 1'b0;
            err = 1'b0;
            eng_cnt = eng_never ? 0 : eng_dly;
         end else if (eng_cnt > 0) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) begin
               ack = 1'b1;
               err = err_bits[eng_idx];
               eng_idx = eng_idx + 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic plan(input bit [7:0] bits, input bit never);
      err_bits  = bits;
      eng_never = never;
      eng_idx   = 0;
   endtask

   task automatic launch(input int it, input int gp, input int tm, output int s_cyc);
      iter_num   = ITER_W'(it);
      gap_cycles = GAP_W'(gp);
      tmo_cycles = TMO_W'(tm);
      start      = 1'b1;
      s_cyc      = cyc;
      tick(1);
      start      = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         tick(1);
         n = n + 1;
      end
      chk(tag, done_cnt - d0, 1);
   endtask

   initial begin
      int s;
      int r0;
      int d0;
      int n;

      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      iter_num   = '0;
      gap_cycles = '0;
      tmo_cycles = '0;
      tick(3);

      // Reset state.
      chk("rst_state",    state, 0);
      chk("rst_req",      req, 0);
      chk("rst_busy",     busy, 0);
      chk("rst_done",     done, 0);
      chk("rst_pass",     pass_cnt, 0);
      chk("rst_fail",     fail_cnt, 0);
      chk("rst_tmo",      tmo_cnt, 0);
      chk("rst_last_err", last_err, 0);
      rst = 1'b0;
      tick(2);

      // 3 iterations, no gap, all pass: req at start+2, spacing 5+2 = 7.
      plan(8'b0000_0000, 1'b0);
      r0 = req_cyc.size();
      launch(3, 0, 0, s);
      tick(1);
      chk("t1_busy", busy, 1);
      wait_done("t1_done", 100);
      chk("t1_reqs",     req_cnt - r0, 3);
      chk("t1_req0_lat", req_cyc[r0] - s, 2);
      chk("t1_spacing",  req_cyc[r0 + 1] - req_cyc[r0], 7);
      chk("t1_pass",     pass_cnt, 3);
      chk("t1_fail",     fail_cnt, 0);
      chk("t1_last_err", last_err, 0);
      chk("t1_busy_end", busy, 0);
      chk("t1_state",    state, 0);
`ifndef AXI_SCHED_TMO_EN
      chk("t1_tmo_tied", tmo_cnt, 0);
`endif

      // 4 iterations, gap 2, error on the 2nd ack: spacing 7 + 2 = 9.
      plan(8'b0000_0010, 1'b0);
      r0 = req_cyc.size();
      launch(4, 2, 0, s);
      wait_done("t2_done", 150);
      chk("t2_reqs",      req_cnt - r0, 4);
      chk("t2_gap_a",     req_cyc[r0 + 1] - req_cyc[r0], 9);
      chk("t2_gap_b",     req_cyc[r0 + 2] - req_cyc[r0 + 1], 9);
      chk("t2_gap_c",     req_cyc[r0 + 3] - req_cyc[r0 + 2], 9);
      chk("t2_pass",      pass_cnt, 3);
      chk("t2_fail",      fail_cnt, 1);
      chk("t2_last_err",  last_err, 0);

      // Single iteration ending in error: counters restart, last_err set.
      plan(8'b0000_0001, 1'b0);
      launch(1, 0, 0, s);
      wait_done("t2b_done", 50);
      chk("t2b_pass",     pass_cnt, 0);
      chk("t2b_fail",     fail_cnt, 1);
      chk("t2b_last_err", last_err, 1);

      // Zero iterations: done two cycles after start, no req, counters cleared.
      r0 = req_cnt;
      launch(0, 0, 0, s);
      wait_done("t3_done", 20);
      chk("t3_done_lat", done_cyc - s, 2);
      chk("t3_reqs",     req_cnt - r0, 0);
      chk("t3_pass",     pass_cnt, 0);
      chk("t3_fail",     fail_cnt, 0);

      // Abort on the same cycle as the 2nd ack of a 5-iteration run.
      plan(8'b0000_0000, 1'b0);
      r0 = req_cnt;
      d0 = done_cnt;
      launch(5, 0, 0, s);
      n = 0;
      while (req_cnt - r0 < 2 && n < 50) begin
         tick(1);
         n = n + 1;
      end
      chk("t4_req2_seen", req_cnt - r0, 2);
      n = 0;
      while (ack !== 1'b1 && n < 20) begin
         tick(1);
         n = n + 1;
      end
      chk("t4_ack_seen", ack, 1);
      chk("t4_in_wait",  state, 2);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t4_state_idle", state, 0);
      tick(20);
      chk("t4_pass",  pass_cnt, 1);
      chk("t4_fail",  fail_cnt, 0);
      chk("t4_reqs",  req_cnt - r0, 2);
      chk("t4_nodone", done_cnt - d0, 0);
      chk("t4_busy",  busy, 0);

      // start held high through most of a 2-iteration run: single run only.
      plan(8'b0000_0000, 1'b0);
      r0 = req_cnt;
      d0 = done_cnt;
      iter_num   = ITER_W'(2);
      gap_cycles = '0;
      tmo_cycles = '0;
      start      = 1'b1;
      tick(10);
      start      = 1'b0;
      wait_done("t5_done", 60);
      tick(15);
      chk("t5_reqs",  req_cnt - r0, 2);
      chk("t5_dones", done_cnt - d0, 1);
      chk("t5_pass",  pass_cnt, 2);

      // start together with abort in idle: nothing launches, counters hold.
      r0 = req_cnt;
      d0 = done_cnt;
      iter_num = ITER_W'(3);
      start    = 1'b1;
      abort    = 1'b1;
      tick(1);
      start    = 1'b0;
      abort    = 1'b0;
      tick(15);
      chk("t5b_reqs",  req_cnt - r0, 0);
      chk("t5b_state", state, 0);
      chk("t5b_dones", done_cnt - d0, 0);
      chk("t5b_pass",  pass_cnt, 2);

`ifdef AXI_SCHED_TMO_EN
      // Engine never acks; 10-cycle watchdog -> req every 11 cycles.
      plan(8'b0000_0000, 1'b1);
      r0 = req_cyc.size();
      launch(2, 0, 10, s);
      wait_done("t6_done", 100);
      chk("t6_reqs",     req_cyc.size() - r0, 2);
      chk("t6_spacing",  req_cyc[r0 + 1] - req_cyc[r0], 11);
      chk("t6_tmo",      tmo_cnt, 2);
      chk("t6_fail",     fail_cnt, 2);
      chk("t6_pass",     pass_cnt, 0);
      chk("t6_last_err", last_err, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
